// File: rtl/geofence_pkg.sv
// Shared types for the convex-polygon geofence checker.
//   coord_t  : unsigned coordinate
//   point_t  : packed {y,x} point
//   CROSS_W  : signed width of a cross product, wide enough that nothing truncates
//   state_t  : controller states
package geofence_pkg;
  localparam int COORD_W = 10;
  localparam int CROSS_W = 2*COORD_W+3;

  typedef logic [COORD_W-1:0] coord_t;
  typedef struct packed {
    coord_t y;
    coord_t x;
  } point_t;

  typedef enum logic [1:0] {LOAD, SORT, TEST, DONE} state_t;
endpackage

// File: rtl/geo_cross.sv
// Combinational signed cross product (b-a) x (d-c).
//   a,b,c,d : points (unsigned coordinates)
//   prod    : signed CROSS_W result, (b-a).x*(d-c).y - (b-a).y*(d-c).x
module geo_cross
  import geofence_pkg::*;
(
  input  point_t                     a,
  input  point_t                     b,
  input  point_t                     c,
  input  point_t                     d,
  output logic signed [CROSS_W-1:0]  prod
);
  localparam int PW = 2*COORD_W+2;

  logic signed [COORD_W:0] abx, aby, cdx, cdy;
  logic signed [PW-1:0]    p0, p1;

  // Zero-extend before subtracting so the differences keep their sign.
  assign abx = $signed({1'b0, b.x}) - $signed({1'b0, a.x});
  assign aby = $signed({1'b0, b.y}) - $signed({1'b0, a.y});
  assign cdx = $signed({1'b0, d.x}) - $signed({1'b0, c.x});
  assign cdy = $signed({1'b0, d.y}) - $signed({1'b0, c.y});

  assign p0 = abx * cdy;
  assign p1 = aby * cdx;

  // One extra sign bit so the difference of two products cannot overflow.
  assign prod = $signed({p0[PW-1], p0}) - $signed({p1[PW-1], p1});
endmodule

// File: rtl/geofence_poly.sv
// Convex polygon geofence: loads a test point plus 3..MAX_VERT unordered
// vertices, sorts them counter-clockwise around V[0] with a shared cross-product
// unit, then tests the point against each edge.
//   clk, reset         : clock, async active-high reset
//   in_valid/in_ready  : input beat handshake (ready only in LOAD)
//   X, Y, nv           : beat coordinates; nv sampled on beat 0 only
//   valid              : one-cycle result strobe
//   is_inside, on_edge : result flags, zero whenever valid is low
module geofence_poly #(
  parameter int COORD_W   = 10,  // must match geofence_pkg::COORD_W
  parameter int MAX_VERT  = 6,
  parameter bit INCLUSIVE = 1'b0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [COORD_W-1:0]            X,
  input  logic [COORD_W-1:0]            Y,
  input  logic [$clog2(MAX_VERT+1)-1:0] nv,
  output logic                          valid,
  output logic                          is_inside,
  output logic                          on_edge
);
  import geofence_pkg::*;

  localparam int NV_W = $clog2(MAX_VERT+1);
  localparam logic [NV_W-1:0] ONE   = NV_W'(1);
  localparam logic [NV_W-1:0] TWO   = NV_W'(2);
  localparam logic [NV_W-1:0] THREE = NV_W'(3);
  localparam logic [NV_W-1:0] VMAX  = NV_W'(MAX_VERT);

  state_t state, state_nx;

  point_t          pin, p_q;
  point_t          v_q [MAX_VERT];
  logic [NV_W-1:0] nv_q, nv_clamp, cnt_q, j_q, pass_q, k_q, kn;
  logic            edge_q, res_in_q, res_edge_q;

  point_t                     op_a, op_b, op_c, op_d;
  logic signed [CROSS_W-1:0]  prod;
  logic                       neg, zero, accept, load_last, j_last, pass_last, k_last;
  logic                       edge_f;

  assign pin = {Y, X};

  always_comb begin
    nv_clamp = nv;
    if (nv < THREE)     nv_clamp = THREE;
    else if (nv > VMAX) nv_clamp = VMAX;
  end

  assign accept    = in_valid && in_ready;
  // cnt_q==0 means the next beat is the point; nv_q is only valid after it.
  assign load_last = accept && (cnt_q != '0) && (cnt_q == nv_q);
  assign j_last    = (j_q == nv_q - TWO);
  assign pass_last = (pass_q == nv_q - THREE);
  assign k_last    = (k_q == nv_q - ONE);
  assign kn        = k_last ? '0 : k_q + ONE;

  assign neg    = prod[CROSS_W-1];
  assign zero   = (prod == '0);
  assign edge_f = edge_q | zero;

  // Single cross unit: angular compare around V[0] in SORT, edge test in TEST.
  always_comb begin
    op_a = v_q[0];
    op_b = v_q[j_q];
    op_c = v_q[0];
    op_d = v_q[j_q + ONE];
    if (state == TEST) begin
      op_a = v_q[k_q];
      op_b = v_q[kn];
      op_c = v_q[k_q];
      op_d = p_q;
    end
  end

  geo_cross u_cross (
    .a    (op_a),
    .b    (op_b),
    .c    (op_c),
    .d    (op_d),
    .prod (prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= LOAD;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: if (load_last)          state_nx = SORT;
      SORT: if (j_last && pass_last) state_nx = TEST;
      TEST: if (neg || k_last)      state_nx = DONE;
      DONE:                         state_nx = LOAD;
      default:                      state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      p_q        <= '0;
      for (int i = 0; i < MAX_VERT; i++) v_q[i] <= '0;
      nv_q       <= THREE;
      cnt_q      <= '0;
      j_q        <= ONE;
      pass_q     <= '0;
      k_q        <= '0;
      edge_q     <= 1'b0;
      res_in_q   <= 1'b0;
      res_edge_q <= 1'b0;
    end else begin
      case (state)
        LOAD: if (accept) begin
          if (cnt_q == '0) begin
            p_q  <= pin;
            nv_q <= nv_clamp;
          end else begin
            v_q[cnt_q - ONE] <= pin;
          end
          if (load_last) begin
            cnt_q  <= '0;
            j_q    <= ONE;
            pass_q <= '0;
          end else begin
            cnt_q <= cnt_q + ONE;
          end
        end
        // Bubble sort over V[1..nv-1]; V[0] is the pivot and never moves.
        SORT: begin
          if (neg) begin
            v_q[j_q]       <= v_q[j_q + ONE];
            v_q[j_q + ONE] <= v_q[j_q];
          end
          if (j_last) begin
            j_q    <= ONE;
            pass_q <= pass_q + ONE;
            if (pass_last) begin
              k_q    <= '0;
              edge_q <= 1'b0;
            end
          end else begin
            j_q <= j_q + ONE;
          end
        end
        TEST: begin
          k_q <= k_q + ONE;
          if (zero) edge_q <= 1'b1;
          if (neg) begin
            res_in_q   <= 1'b0;
            res_edge_q <= 1'b0;
          end else if (k_last) begin
            res_edge_q <= edge_f;
            res_in_q   <= !edge_f || (INCLUSIVE && edge_f);
          end
        end
        DONE: begin
          res_in_q   <= 1'b0;
          res_edge_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == LOAD);
  assign valid     = (state == DONE);
  assign is_inside = valid && res_in_q;
  assign on_edge   = valid && res_edge_q;
endmodule

// File: tb/tb_geofence_poly.sv
module tb_geofence_poly;
  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic [9:0] X, Y;
  logic [2:0] nv;
  logic       rdy0, val0, in0, edg0;
  logic       rdy1, val1, in1, edg1;

  always #5 clk = ~clk;

  geofence_poly #(.COORD_W(10), .MAX_VERT(6), .INCLUSIVE(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy0),
    .X(X), .Y(Y), .nv(nv), .valid(val0), .is_inside(in0), .on_edge(edg0));

  geofence_poly #(.COORD_W(10), .MAX_VERT(6), .INCLUSIVE(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy1),
    .X(X), .Y(Y), .nv(nv), .valid(val1), .is_inside(in1), .on_edge(edg1));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  typedef struct {
    string name;
    int    px, py, nvreq, ncnt;
    int    vx[6];
    int    vy[6];
    int    lat, in0, in1, edg;
    bit    gaps;
  } vec_t;

  function automatic vec_t mk(input string nm, input int px, input int py,
                              input int nvreq, input int ncnt, input int sel,
                              input int lat, input int e_in0, input int e_in1,
                              input int e_edg, input bit gaps);
    vec_t t;
    t.name = nm; t.px = px; t.py = py; t.nvreq = nvreq; t.ncnt = ncnt;
    t.lat = lat; t.in0 = e_in0; t.in1 = e_in1; t.edg = e_edg; t.gaps = gaps;
    case (sel)
      0: begin t.vx = '{100, 200, 50, 250, 100, 200}; t.vy = '{0, 200, 100, 100, 200, 0}; end
      1: begin t.vx = '{0, 0, 10, 0, 0, 0};           t.vy = '{10, 0, 0, 0, 0, 0};        end
      default: begin t.vx = '{0, 1023, 1023, 0, 0, 0}; t.vy = '{0, 1023, 0, 1023, 0, 0}; end
    endcase
    return t;
  endfunction

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic beat(input int x, input int y, input int n);
    int w = 0;
    X = 10'(x); Y = 10'(y); nv = 3'(n); in_valid = 1'b1;
    while (!(rdy0 && rdy1) && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) chk("ready_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_job(input vec_t t);
    beat(t.px, t.py, t.nvreq);
    for (int i = 0; i < t.ncnt; i++) begin
      if (t.gaps) repeat ($urandom_range(0, 3)) @(negedge clk);
      beat(t.vx[i], t.vy[i], 0);
    end
  endtask

  task automatic run_job(input vec_t t, input bit junk);
    int cyc;
    load_job(t);
    // Junk beats offered while busy must not be consumed.
    if (junk) begin X = 10'd7; Y = 10'd7; nv = 3'd3; in_valid = 1'b1; end
    cyc = 1;
    while (!val0 && cyc < 100) begin @(negedge clk); cyc++; end
    in_valid = 1'b0;
    if (cyc >= 100) chk({t.name, "_timeout"}, 0, 1);
    chk({t.name, "_latency"}, cyc, t.lat);
    chk({t.name, "_valid_inc"}, int'(val1), 1);
    chk({t.name, "_inside"}, int'(in0), t.in0);
    chk({t.name, "_inside_inc"}, int'(in1), t.in1);
    chk({t.name, "_on_edge"}, int'(edg0), t.edg);
    chk({t.name, "_on_edge_inc"}, int'(edg1), t.edg);
    chk({t.name, "_ready_done"}, int'(rdy0), 0);
    @(negedge clk);
    chk({t.name, "_valid_drop"}, int'(val0 | val1), 0);
    chk({t.name, "_flags_drop"}, int'(in0 | edg0 | in1 | edg1), 0);
    chk({t.name, "_ready_back"}, int'(rdy0 & rdy1), 1);
  endtask

  vec_t tv[10];

  initial begin
    bit saw;
    reset = 1'b1; in_valid = 1'b0; X = '0; Y = '0; nv = '0;

    tv[0] = mk("hex_in",    150, 100, 6, 6, 0, 23, 1, 1, 0, 1'b0);
    tv[1] = mk("hex_out",   300, 100, 6, 6, 0, 19, 0, 0, 0, 1'b0);
    tv[2] = mk("hex_edge",  150,   0, 6, 6, 0, 23, 0, 1, 1, 1'b0);
    tv[3] = mk("tri_in",      2,   2, 3, 3, 1,  5, 1, 1, 0, 1'b0);
    tv[4] = mk("tri_out",     9,   9, 3, 3, 1,  5, 0, 0, 0, 1'b0);
    tv[5] = mk("sq_in",    1022,   1, 4, 4, 2,  9, 1, 1, 0, 1'b0);
    tv[6] = mk("sq_edge",  1023, 512, 4, 4, 2,  9, 0, 1, 1, 1'b0);
    tv[7] = mk("clamp_hi",  150, 100, 7, 6, 0, 23, 1, 1, 0, 1'b0);
    tv[8] = mk("clamp_lo",    2,   2, 0, 3, 1,  5, 1, 1, 0, 1'b0);
    tv[9] = mk("gaps_in",   150, 100, 6, 6, 0, 23, 1, 1, 0, 1'b1);

    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", int'(val0 | val1), 0);
    chk("rst_inside", int'(in0 | in1), 0);
    chk("rst_on_edge", int'(edg0 | edg1), 0);
    chk("rst_ready", int'(rdy0 & rdy1), 1);

    // Jobs run back-to-back: each starts in the first LOAD cycle after DONE.
    for (int i = 0; i < 10; i++) run_job(tv[i], tv[i].gaps);

    // Reset in the middle of SORT.
    load_job(tv[0]);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_valid", int'(val0 | val1), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_ready", int'(rdy0 & rdy1), 1);
    saw = 1'b0;
    repeat (30) begin @(negedge clk); if (val0 || val1) saw = 1'b1; end
    chk("midrst_no_pulse", int'(saw), 0);
    run_job(tv[3], 1'b1);
    run_job(tv[1], 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
